hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_perf_cnt.sv | 37 +++
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and widths for the hazard/stall controller.
// State encoding is fixed (RUN=0, MEM_WAIT=1, REDIRECT=2) so debug tools can decode it.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } hz_state_e;

    // Wait counter must hold MEM_TIMEOUT up to 65535.
    localparam int WAIT_CNT_W  = 16;
    // Redirect counter holds FLUSH_CYCLES-1, at most 3.
    localparam int REDIR_CNT_W = 3;
    // Performance counters wrap at 32 bits.
    localparam int PERF_CNT_W  = 32;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signals seen by the hazard controller.
// master = pipeline datapath (drives hazard sources, consumes controls),
// slave  = hazard_ctrl.
// Data-memory handshake: an access is outstanding while mem_req is high;
// it completes in the cycle where mem_req and mem_ready are both high.
// A cycle with mem_req high and mem_ready low is a wait state. Dropping
// mem_req also ends the wait.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_load;
    logic [4:0] ex_rd;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_ready;

    logic       pc_stall;
    logic       if_id_stall;
    logic       id_ex_stall;
    logic       ex_mem_stall;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       mem_wb_bubble;
    logic       fwd_load_block;
    logic       mem_timeout_err;
    hz_state_e  state;          // debug view of the controller FSM

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_load, ex_rd,
               branch_taken, mem_req, mem_ready,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
               id_ex_bubble, mem_wb_bubble, fwd_load_block, mem_timeout_err, state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_load, ex_rd,
               branch_taken, mem_req, mem_ready,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
               id_ex_bubble, mem_wb_bubble, fwd_load_block, mem_timeout_err, state
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: wrapping 32-bit counters of stall cycles and accepted
// taken branches. Only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic [PERF_CNT_W-1:0] stall_cycles_o,
    output logic [PERF_CNT_W-1:0] flush_count_o
);

    logic [PERF_CNT_W-1:0] stall_q, stall_d;
    logic [PERF_CNT_W-1:0] flush_q, flush_d;

    // Next counts: add one per qualifying cycle, wrap naturally.
    always_comb begin
        stall_d = stall_q + {{(PERF_CNT_W-1){1'b0}}, stall_i};
        flush_d = flush_q + {{(PERF_CNT_W-1){1'b0}}, flush_i};
    end

    // Counter registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-redirect / memory-wait hazard controller
// for the 5-stage core. Controls are combinational from state and inputs;
// state, counters and the sticky timeout flag are registered.
// Optional feature macro: HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_count performance counter ports.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,    // 1..4
    parameter int MEM_TIMEOUT  = 255   // 1..65535
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_ctrl_if.slave          hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_count
`endif
);

    localparam logic [WAIT_CNT_W-1:0]  TIMEOUT_V   = WAIT_CNT_W'(MEM_TIMEOUT);
    localparam logic [REDIR_CNT_W-1:0] FLUSH_M1    = REDIR_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [REDIR_CNT_W-1:0] REDIR_ONE   = REDIR_CNT_W'(1);
    localparam bit                     MULTI_FLUSH = (FLUSH_CYCLES > 1);

    hz_state_e               state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [REDIR_CNT_W-1:0]  redir_cnt_q, redir_cnt_d;
    logic                    pend_q, pend_d;    // redirect interrupted by a memory wait
    logic                    err_q, err_d;

    logic                    mem_busy;
    logic                    load_use;
    logic                    br_accept;
    logic [WAIT_CNT_W-1:0]   wait_inc;

    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic if_id_flush, id_ex_bubble, mem_wb_bubble;

    assign mem_busy  = hz.mem_req & ~hz.mem_ready;
    assign load_use  = hz.ex_load & (hz.ex_rd != 5'd0) &
                       ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                        (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
    assign br_accept = hz.branch_taken & ~mem_busy;
    // Wait count saturates at the timeout value; the error flag is sticky anyway.
    assign wait_inc  = (wait_cnt_q == TIMEOUT_V) ? wait_cnt_q : wait_cnt_q + 1'b1;

    // Hazard priority (mem_busy > branch > redirect continuation > load_use) and next state.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        redir_cnt_d   = redir_cnt_q;
        pend_d        = pend_q;
        err_d         = err_q;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;

        if (mem_busy) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = MEM_WAIT;
            wait_cnt_d    = wait_inc;
            if (state_q == REDIRECT) begin
                pend_d = 1'b1;              // remaining flush count is kept as-is
            end
            if (wait_inc == TIMEOUT_V) begin
                err_d = 1'b1;
            end
        end else begin
            wait_cnt_d = '0;
            pend_d     = 1'b0;
            if (br_accept) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (MULTI_FLUSH) begin
                    state_d     = REDIRECT;
                    redir_cnt_d = FLUSH_M1;
                end else begin
                    state_d = RUN;
                end
            end else if ((state_q == REDIRECT) || ((state_q == MEM_WAIT) && pend_q)) begin
                // Redirect continues (or resumes right after a memory wait).
                // ID holds a flushed slot, so load_use is not evaluated here.
                if_id_flush = 1'b1;
                redir_cnt_d = redir_cnt_q - 1'b1;
                state_d     = (redir_cnt_q > REDIR_ONE) ? REDIRECT : RUN;
            end else begin
                state_d = RUN;
                if (load_use) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
            end
        end

        if (rst) begin
            pc_stall      = 1'b0;
            if_id_stall   = 1'b0;
            id_ex_stall   = 1'b0;
            ex_mem_stall  = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_bubble  = 1'b0;
            mem_wb_bubble = 1'b0;
        end
    end

    // State, counters and sticky error; reset aborts any wait or redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            redir_cnt_q <= '0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            redir_cnt_q <= redir_cnt_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
        end
    end

    assign hz.pc_stall        = pc_stall;
    assign hz.if_id_stall     = if_id_stall;
    assign hz.id_ex_stall     = id_ex_stall;
    assign hz.ex_mem_stall    = ex_mem_stall;
    assign hz.if_id_flush     = if_id_flush;
    assign hz.id_ex_bubble    = id_ex_bubble;
    assign hz.mem_wb_bubble   = mem_wb_bubble;
    assign hz.fwd_load_block  = hz.ex_load & ~rst;
    assign hz.mem_timeout_err = err_q & ~rst;
    assign hz.state           = rst ? RUN : state_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (pc_stall),
        .flush_i        (br_accept & ~rst),
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int FC     = 3;
    localparam int MT     = 8;
    localparam int N_RAND = 3000;

    logic clk;
    logic rst;
    hazard_ctrl_if bus ();
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
    //  id_ex_bubble, mem_wb_bubble, fwd_load_block, mem_timeout_err}
    function automatic logic [8:0] ctrl_vec();
        return {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall,
                bus.if_id_flush, bus.id_ex_bubble, bus.mem_wb_bubble,
                bus.fwd_load_block, bus.mem_timeout_err};
    endfunction

    // ---------------- behavioural model ----------------
    // flush_left: flush cycles still owed to the last taken branch (survives a memory wait)
    // wait_len:   consecutive wait-state cycles
    int          m_flush_left = 0, n_flush_left = 0;
    int          m_wait = 0, n_wait = 0;
    bit          m_err = 0, n_err = 0;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] m_stall = 0, n_stall = 0;
    logic [31:0] m_flushes = 0, n_flushes = 0;
`endif

    function automatic bit load_use_ref();
        bit hit1, hit2;
        hit1 = bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd);
        hit2 = bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd);
        return bus.ex_load && (bus.ex_rd != 5'd0) && (hit1 || hit2);
    endfunction

    // Compare process: expected controls from the rules, then next model state.
    always @(negedge clk) begin
        bit busy, lu;
        bit e_stall_all, e_lu, e_flush, e_bubble, e_fwd, e_err;
        busy = bus.mem_req && !bus.mem_ready;
        lu   = load_use_ref();
        e_stall_all = 0; e_lu = 0; e_flush = 0; e_bubble = 0; e_fwd = 0; e_err = 0;
        if (!rst) begin
            e_fwd = bus.ex_load;
            e_err = m_err;
            if (busy)                   e_stall_all = 1;
            else if (bus.branch_taken) begin e_flush = 1; e_bubble = 1; end
            else if (m_flush_left > 0)  e_flush = 1;
            else if (lu)                begin e_lu = 1; e_bubble = 1; end
        end
        check("model_ctrl", ctrl_vec(),
              {e_stall_all | e_lu, e_stall_all | e_lu, e_stall_all, e_stall_all,
               e_flush, e_bubble, e_stall_all, e_fwd, e_err});
`ifdef HAZARD_PERF_CNT_EN
        check("model_stall_cycles", stall_cycles, m_stall);
        check("model_flush_count", flush_count, m_flushes);
`endif
        if (rst) begin
            n_flush_left = 0; n_wait = 0; n_err = 0;
`ifdef HAZARD_PERF_CNT_EN
            n_stall = 0; n_flushes = 0;
`endif
        end else begin
            n_flush_left = m_flush_left;
            n_err        = m_err;
`ifdef HAZARD_PERF_CNT_EN
            n_stall   = m_stall + ((e_stall_all | e_lu) ? 32'd1 : 32'd0);
            n_flushes = m_flushes;
`endif
            if (busy) begin
                n_wait = m_wait + 1;
                if (n_wait >= MT) n_err = 1;
            end else begin
                n_wait = 0;
                if (bus.branch_taken) begin
                    n_flush_left = FC - 1;
`ifdef HAZARD_PERF_CNT_EN
                    n_flushes = m_flushes + 1;
`endif
                end else if (m_flush_left > 0) begin
                    n_flush_left = m_flush_left - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        m_flush_left = n_flush_left;
        m_wait       = n_wait;
        m_err        = n_err;
`ifdef HAZARD_PERF_CNT_EN
        m_stall      = n_stall;
        m_flushes    = n_flushes;
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
        bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
        bus.ex_load = 1'b0; bus.ex_rd = 5'd0;
        bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic busy_cycle(input logic br);
        idle();
        bus.mem_req = 1'b1;
        bus.branch_taken = br;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1'b1;
        idle();
        repeat (2) tick();

        // Reset with every hazard source active: controls stay low, state RUN.
        busy_cycle(1'b1);
        bus.ex_load = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
        @(negedge clk);
        check("reset_ctrl", ctrl_vec(), 9'b000000000);
        check("reset_state", 32'(bus.state), 32'(RUN));

        tick(); rst = 1'b0; idle();
        @(negedge clk);
        check("idle", ctrl_vec(), 9'b000000000);

        // lw x5 in EX, add x6,x5,x1 in ID.
        tick(); idle();
        bus.ex_load = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1; bus.id_rs2 = 5'd1; bus.id_uses_rs2 = 1'b1;
        @(negedge clk);
        check("lu_stall", ctrl_vec(), 9'b110001010);
        tick(); bus.ex_load = 1'b0; bus.ex_rd = 5'd0;
        @(negedge clk);
        check("lu_release", ctrl_vec(), 9'b000000000);

        // addi reading only rs1; rs2 field matches but is unused.
        tick(); idle();
        bus.ex_load = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd1; bus.id_uses_rs1 = 1'b1; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b0;
        @(negedge clk);
        check("lu_rs2_unused", ctrl_vec(), 9'b000000010);
        // Load to x0 never stalls.
        tick(); idle();
        bus.ex_load = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b1;
        @(negedge clk);
        check("lu_x0", ctrl_vec(), 9'b000000010);

        // Taken branch: FC flush cycles, bubble only on the first.
        tick(); idle(); bus.branch_taken = 1'b1;
        @(negedge clk);
        check("br_first", ctrl_vec(), 9'b000011000);
        for (int i = 0; i < FC - 1; i++) begin
            tick(); idle();
            @(negedge clk);
            check("br_cont", ctrl_vec(), 9'b000010000);
        end
`ifdef HAZARD_PERF_CNT_EN
        check("br_flush_count", flush_count, 32'd1);
`endif
        tick(); idle();
        @(negedge clk);
        check("br_done", ctrl_vec(), 9'b000000000);

        // Four wait states, then completion.
        for (int i = 0; i < 4; i++) begin
            tick(); busy_cycle(1'b0);
            @(negedge clk);
            check("mw_stall", ctrl_vec(), 9'b111100100);
        end
        tick(); idle(); bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk);
        check("mw_done", ctrl_vec(), 9'b000000000);
`ifdef HAZARD_PERF_CNT_EN
        check("mw_stall_cycles", stall_cycles, 32'd5);
`endif

        // Branch coinciding with load_use: branch wins.
        tick(); idle();
        bus.branch_taken = 1'b1; bus.ex_load = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
        @(negedge clk);
        check("br_lu", ctrl_vec(), 9'b000011010);
        for (int i = 0; i < FC - 1; i++) begin
            tick(); idle();
            @(negedge clk);
            check("br_lu_cont", ctrl_vec(), 9'b000010000);
        end

        // Branch held in EX during a memory wait; accepted once the wait ends.
        for (int i = 0; i < 3; i++) begin
            tick(); busy_cycle(1'b1);
            @(negedge clk);
            check("br_mw_hold", ctrl_vec(), 9'b111100100);
        end
        tick(); idle(); bus.mem_req = 1'b1; bus.mem_ready = 1'b1; bus.branch_taken = 1'b1;
        @(negedge clk);
        check("br_mw_accept", ctrl_vec(), 9'b000011000);
        for (int i = 0; i < FC - 1; i++) begin
            tick(); idle();
            @(negedge clk);
            check("br_mw_cont", ctrl_vec(), 9'b000010000);
        end

        // Redirect interrupted by a memory wait resumes with the remaining count.
        tick(); idle(); bus.branch_taken = 1'b1;
        @(negedge clk);
        check("pre_br", ctrl_vec(), 9'b000011000);
        for (int i = 0; i < 2; i++) begin
            tick(); busy_cycle(1'b0);
            @(negedge clk);
            check("pre_wait", ctrl_vec(), 9'b111100100);
        end
        tick(); idle(); bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk);
        check("pre_resume1", ctrl_vec(), 9'b000010000);
        tick(); idle();
        @(negedge clk);
        check("pre_resume2", ctrl_vec(), 9'b000010000);
        tick(); idle();
        @(negedge clk);
        check("pre_done", ctrl_vec(), 9'b000000000);
`ifdef HAZARD_PERF_CNT_EN
        check("pre_flush_count", flush_count, 32'd4);
        check("pre_stall_cycles", stall_cycles, 32'd10);
`endif

        // Timeout: error rises after MT wait cycles and sticks until reset.
        for (int i = 0; i < MT; i++) begin
            tick(); busy_cycle(1'b0);
            @(negedge clk);
            check("to_wait", ctrl_vec(), 9'b111100100);
        end
        tick(); busy_cycle(1'b0);
        @(negedge clk);
        check("to_err", ctrl_vec(), 9'b111100101);
        tick(); idle(); bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk);
        check("to_sticky", ctrl_vec(), 9'b000000001);
        tick(); busy_cycle(1'b0);
        @(negedge clk);
        check("to_rewait", ctrl_vec(), 9'b111100101);
        tick(); busy_cycle(1'b0); rst = 1'b1;
        @(negedge clk);
        check("to_rst_ctrl", ctrl_vec(), 9'b000000000);
        check("to_rst_state", 32'(bus.state), 32'(RUN));
        tick(); rst = 1'b0; idle();
        @(negedge clk);
        check("to_cleared", ctrl_vec(), 9'b000000000);

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < N_RAND; i++) begin
            tick();
            rst              = ($urandom_range(0, 99) == 0);
            bus.mem_req      = ($urandom_range(0, 9) < 3);
            bus.mem_ready    = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            bus.branch_taken = ($urandom_range(0, 9) == 0);
            bus.ex_load      = ($urandom_range(0, 9) < 4);
            bus.ex_rd        = 5'($urandom_range(0, 3));
            bus.id_rs1       = 5'($urandom_range(0, 3));
            bus.id_rs2       = 5'($urandom_range(0, 3));
            bus.id_uses_rs1  = 1'($urandom_range(0, 1));
            bus.id_uses_rs2  = 1'($urandom_range(0, 1));
        end
        tick(); rst = 1'b0; idle();
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
